xbar_switch: RTL
================

Name: xbar_switch

Overview:
- Parametrised NPORTS x NPORTS registered crossbar for the mesh router; next generation of the fixed 5x5, 4-bit crossbar.
- Adds per-port valid/ready flow control, a one-entry output register per output, multicast (one input driving several outputs), and sticky detection of illegal selects.
- Sits between the router's switch allocator (which drives the selects) and the output links / downstream input buffers.

Parameters:
- NPORTS, 5, number of input ports and of output ports (0=local, 1=N, 2=E, 3=S, 4=W for the mesh router).
- DW, 4, flit data width in bits.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NPORTS*DW  flattened input flits; port i occupies bits [i*DW +: DW].
- in_valid  input  NPORTS  input flit valid, one bit per input.
- in_ready  output  NPORTS  input flit accepted this cycle (combinational).
- sel  input  NPORTS*NPORTS  per-output one-hot source select; output j uses bits [j*NPORTS +: NPORTS], and bit i selects input i.
- out_data  output  NPORTS*DW  registered output flits, same packing as in_data.
- out_valid  output  NPORTS  output register holds a flit.
- out_ready  input  NPORTS  downstream accepts the output flit.
- sel_err  output  NPORTS  sticky flag per output: a multi-hot select was seen on that output.
- clr_err  input  1  synchronous clear of all sel_err bits.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, sel_err=0, held until rst deasserts. Reset mid-transfer drops the held flits silently.
- Select decode, per output j:
  - sel_j zero-hot: output idle, no load.
  - sel_j one-hot: output j is connected to input src_j.
  - sel_j multi-hot: treated as idle, and sel_err[j] is set on the next edge.
- accept_j = !out_valid[j] | out_ready[j]; the output slot can take a new flit this cycle.
- in_ready[i] = 1 only if at least one legal output selects i and every legal output selecting i has accept=1. This gives all-or-nothing multicast.
- Inputs selected by no legal output: in_ready=0.
- in_ready does not depend on in_valid.
- Transfer: when in_valid[i] & in_ready[i], every legal output selecting i loads in_data[i] on the next edge: out_data_j <= flit, out_valid[j] <= 1.
- Latency is exactly 1 cycle from input handshake to out_valid.
- Throughput is 1 flit/cycle/output when out_ready is held at 1. Load and drain in the same cycle are allowed; the new flit replaces the drained one.
- No load while out_valid[j]=1 and out_ready[j]=1: out_valid[j] <= 0, and out_data holds its last value.
- No load while out_valid[j]=1 and out_ready[j]=0: out_valid and out_data both hold. The output is stable under backpressure.
- Changing sel while an output holds a flit does not disturb the held flit; sel only affects new loads.
- sel_err priority: set on a multi-hot select, cleared by clr_err. If both happen in the same cycle, set wins.
- No X is ever driven on out_data, including for illegal selects.

Decomposition:
- Package noc_xbar_pkg holds:
  - default DW and NPORTS;
  - port index constants PORT_LOCAL=0, PORT_N=1, PORT_E=2, PORT_S=3, PORT_W=4;
  - a function onehot_check(vector) returning zero / one / multi.
- Sub-module xbar_out_slot is the one-entry output register with valid/ready and sel_err logic, instantiated NPORTS times in a generate loop.
- The top level holds select decode, the per-input ready reduction and the data muxes.

Test Plan:
- Reset: drive rst=1 mid-stream with out_valid=5'b10101 -> out_valid=0, out_data=0, sel_err=0 immediately, without waiting for a clock edge.
- Unicast: sel0=00010, in_data[1]=4'hA, in_valid[1]=1, out_ready=all 1 -> in_ready[1]=1; next cycle out_valid[0]=1, out_data[0]=4'hA.
- Backpressure: output 2 holds 4'h5 with out_ready[2]=0; a new flit 4'h6 is offered on the selected input -> in_ready=0, out_data[2] stays 4'h5. Raise out_ready[2] -> 4'h6 appears one cycle later.
- Multicast all-or-nothing: input 3 selected by outputs 1 and 4, output 4 full with out_ready[4]=0 -> in_ready[3]=0 and neither output loads. Release output 4 -> both outputs load input 3's flit on the same edge.
- Illegal select: sel2=00110 with in_valid=all 1 -> out_valid[2] stays 0 and sel_err[2]=1 next cycle. Pulse clr_err -> sel_err[2]=0. clr_err together with a fresh multi-hot select -> sel_err[2] stays 1.
- Full throughput: five disjoint unicast permutations (output j <- input (j+1)%5) for 8 cycles, out_ready=all 1 -> 40 flits delivered in order, with no bubbles after the first cycle.

Source files
------------

// File: rtl/noc_xbar_pkg.sv
// Shared constants and helpers for the mesh router crossbar.
// Holds default sizes, mesh port indices and the select classifier.
package noc_xbar_pkg;

   localparam int XBAR_NPORTS = 5;
   localparam int XBAR_DW     = 4;

   localparam int PORT_LOCAL = 0;
   localparam int PORT_N     = 1;
   localparam int PORT_E     = 2;
   localparam int PORT_S     = 3;
   localparam int PORT_W     = 4;

   typedef enum logic [1:0] {
      OH_ZERO,
      OH_ONE,
      OH_MULTI
   } oh_t;

   // Classifies a select vector (zero-extended to 32 bits).
   function automatic oh_t onehot_check(input logic [31:0] v);
      oh_t r;
      if (v == '0)
         r = OH_ZERO;
      else if ((v & (v - 32'd1)) == '0)
         r = OH_ONE;
      else
         r = OH_MULTI;
      return r;
   endfunction

endpackage

// File: rtl/xbar_out_slot.sv
// One-entry output register with valid/ready and sticky select error.
// Ports: load/din from the mux, out_data/out_valid/out_ready to the link,
// accept back to the ready reduction, multi/clr_err drive sel_err.
module xbar_out_slot
   import noc_xbar_pkg::*;
#(
   parameter int DW = XBAR_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] din,
   input  logic          multi,
   input  logic          clr_err,
   input  logic          out_ready,
   output logic          accept,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   output logic          sel_err
);

   assign accept = !out_valid | out_ready;

   // Load only arrives when accept is high, so a load always wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= din;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Set beats clear when both occur in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sel_err <= 1'b0;
      else if (multi)
         sel_err <= 1'b1;
      else if (clr_err)
         sel_err <= 1'b0;
   end

endmodule

// File: rtl/xbar_switch.sv
// NPORTS x NPORTS registered crossbar with valid/ready and multicast.
// Ports: in_* flits from input buffers, sel from the switch allocator,
// out_* registered flits to links, sel_err sticky per-output flags.
module xbar_switch
   import noc_xbar_pkg::*;
#(
   parameter int NPORTS = XBAR_NPORTS,
   parameter int DW     = XBAR_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NPORTS*DW-1:0] in_data,
   input  logic [NPORTS-1:0]    in_valid,
   output logic [NPORTS-1:0]    in_ready,
   input  logic [NPORTS*NPORTS-1:0] sel,
   output logic [NPORTS*DW-1:0] out_data,
   output logic [NPORTS-1:0]    out_valid,
   input  logic [NPORTS-1:0]    out_ready,
   output logic [NPORTS-1:0]    sel_err,
   input  logic                 clr_err
);

   logic [NPORTS-1:0] legal;
   logic [NPORTS-1:0] accept;
   logic [NPORTS-1:0] used_m;
   logic [NPORTS-1:0] blk_m;

   // An input is ready only if every legal output picking it can accept.
   always_comb begin
      used_m = '0;
      blk_m  = '0;
      for (int i = 0; i < NPORTS; i++) begin
         for (int j = 0; j < NPORTS; j++) begin
            if (legal[j] && sel[j*NPORTS+i]) begin
               used_m[i] = 1'b1;
               if (!accept[j])
                  blk_m[i] = 1'b1;
            end
         end
      end
   end

   assign in_ready = used_m & ~blk_m;

   for (genvar j = 0; j < NPORTS; j++) begin : g_out
      logic [NPORTS-1:0] src;
      logic [DW-1:0]     mux;
      logic              load;
      logic              multi;
      oh_t               oh;

      assign src   = sel[j*NPORTS +: NPORTS];
      assign oh    = onehot_check(32'(src));
      assign legal[j] = (oh == OH_ONE);
      assign multi = (oh == OH_MULTI);

      // AND-OR mux keeps out_data X-free for any select pattern.
      always_comb begin
         mux = '0;
         for (int i = 0; i < NPORTS; i++)
            if (src[i])
               mux = mux | in_data[i*DW +: DW];
      end

      assign load = legal[j] & |(src & in_valid & in_ready);

      xbar_out_slot #(.DW(DW)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (load),
         .din       (mux),
         .multi     (multi),
         .clr_err   (clr_err),
         .out_ready (out_ready[j]),
         .accept    (accept[j]),
         .out_data  (out_data[j*DW +: DW]),
         .out_valid (out_valid[j]),
         .sel_err   (sel_err[j])
      );
   end

endmodule
